// File: rtl/division_result_stage_if.sv
// Handshake bundle between the division datapath, the result stage and the consumer.
// The result stage takes the slave side; the producer/consumer pair takes the master side.
interface division_result_stage_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
);
   localparam int FW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic [WIDTH-1:0] in_quotient;
   logic [WIDTH:0]   in_remainder;
   logic [WIDTH-1:0] in_divisor;
   logic [WIDTH-1:0] in_dividend;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_quotient;
   logic [WIDTH-1:0] out_remainder;
   logic             out_div_by_zero;
   logic             drop_err;
   logic [FW-1:0]    fill;

   modport master (
      output in_valid, in_quotient, in_remainder, in_divisor, in_dividend, out_ready,
      input  in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero, drop_err, fill
   );

   modport slave (
      input  in_valid, in_quotient, in_remainder, in_divisor, in_dividend, out_ready,
      output in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero, drop_err, fill
   );
endinterface

// File: rtl/division_result_stage.sv
// Final stage of the non-restoring divider: fixes up a negative remainder, flags
// divide-by-zero, and buffers corrected results in a small FIFO behind valid/ready.
module division_result_stage #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input logic clk,
   input logic rst,
   division_result_stage_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int FW = PW + 1;

   // Correction register (stage 1)
   logic             s1Valid_q, s1Valid_d;
   logic [WIDTH-1:0] s1Quot_q, s1Quot_d;
   logic [WIDTH-1:0] s1Rem_q, s1Rem_d;
   logic             s1Dbz_q, s1Dbz_d;

   // FIFO storage and bookkeeping (stage 2)
   logic [WIDTH-1:0] memQuot_q [DEPTH];
   logic [WIDTH-1:0] memRem_q [DEPTH];
   logic             memDbz_q [DEPTH];
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             dropErr_q, dropErr_d;

   logic             inReady;
   logic             acceptIn;
   logic             pushFifo;
   logic             popFifo;
   logic             headValid;
   logic [FW:0]      occupancy;
   logic [WIDTH:0]   remSum;

   // Room exists only if the FIFO plus the in-flight correction entry leave a free slot;
   // this never looks at in_valid so the producer sees a clean ready.
   always_comb begin
      occupancy = {1'b0, fill_q} + (FW + 1)'(s1Valid_q);
      inReady   = occupancy < (FW + 1)'(DEPTH);
      acceptIn  = bus.in_valid && inReady;
      headValid = fill_q != '0;
      pushFifo  = s1Valid_q;
      popFifo   = headValid && bus.out_ready;
   end

   // Remainder fix-up: a negative raw remainder gets the divisor added back, carry dropped.
   always_comb begin
      remSum   = bus.in_remainder + {1'b0, bus.in_divisor};
      s1Valid_d = acceptIn;
      s1Quot_d  = s1Quot_q;
      s1Rem_d   = s1Rem_q;
      s1Dbz_d   = s1Dbz_q;
      if (acceptIn) begin
         if (bus.in_divisor == '0) begin
            s1Quot_d = '1;
            s1Rem_d  = bus.in_dividend;
            s1Dbz_d  = 1'b1;
         end else if (bus.in_remainder[WIDTH]) begin
            s1Quot_d = bus.in_quotient;
            s1Rem_d  = remSum[WIDTH-1:0];
            s1Dbz_d  = 1'b0;
         end else begin
            s1Quot_d = bus.in_quotient;
            s1Rem_d  = bus.in_remainder[WIDTH-1:0];
            s1Dbz_d  = 1'b0;
         end
      end
   end

   // FIFO pointer/occupancy next state; pop is decided from the pre-edge head so a
   // freshly pushed entry is always visible for a cycle before it can leave.
   always_comb begin
      wrPtr_d   = pushFifo ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d   = popFifo ? rdPtr_q + 1'b1 : rdPtr_q;
      fill_d    = fill_q;
      dropErr_d = dropErr_q || (bus.in_valid && !inReady);
      case ({pushFifo, popFifo})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
   end

   // Control state with synchronous reset; a reset also discards the stage-1 entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid_q <= 1'b0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         fill_q    <= '0;
         dropErr_q <= 1'b0;
      end else begin
         s1Valid_q <= s1Valid_d;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         fill_q    <= fill_d;
         dropErr_q <= dropErr_d;
      end
   end

   // Data payload registers need no reset; validity is tracked by the control state.
   always_ff @(posedge clk) begin
      s1Quot_q <= s1Quot_d;
      s1Rem_q  <= s1Rem_d;
      s1Dbz_q  <= s1Dbz_d;
      if (pushFifo && !rst) begin
         memQuot_q[wrPtr_q] <= s1Quot_q;
         memRem_q[wrPtr_q]  <= s1Rem_q;
         memDbz_q[wrPtr_q]  <= s1Dbz_q;
      end
   end

   // Outputs come straight from the head entry and read zero when the FIFO is empty.
   always_comb begin
      bus.in_ready        = inReady;
      bus.out_valid       = headValid;
      bus.out_quotient    = headValid ? memQuot_q[rdPtr_q] : '0;
      bus.out_remainder   = headValid ? memRem_q[rdPtr_q] : '0;
      bus.out_div_by_zero = headValid ? memDbz_q[rdPtr_q] : 1'b0;
      bus.drop_err        = dropErr_q;
      bus.fill            = fill_q;
   end
endmodule

// File: tb/tb_division_result_stage.sv
// Bench for division_result_stage: a queue-based reference model plus directed and
// randomized traffic, compared against the DUT on every falling edge.
module tb_division_result_stage;
   localparam int WIDTH = 16;
   localparam int DEPTH = 2;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
   } entry_t;

   logic clk = 1'b0;
   logic rst;
   int   testsRun = 0;
   int   testsFailed = 0;
   bit   checkEn = 0;

   entry_t modelFifo[$];
   entry_t modelStage[$];
   bit     modelDrop = 0;

   division_result_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   division_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Corrected result straight from the arithmetic meaning of quotient/remainder
   function automatic entry_t correctEntry(logic [15:0] q, logic [16:0] rem,
                                           logic [15:0] dv, logic [15:0] dd);
      entry_t e;
      int     r;
      if (dv == 16'd0) begin
         e.q   = 16'hFFFF;
         e.r   = dd;
         e.dbz = 1'b1;
      end else begin
         r = rem[16] ? int'({15'd0, rem}) - 131072 : int'({15'd0, rem});
         if (r < 0) r = r + int'({16'd0, dv});
         r     = r & 32'h0000FFFF;
         e.q   = q;
         e.r   = r[15:0];
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   function automatic bit modelReady();
      return (modelFifo.size() + modelStage.size()) < DEPTH;
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model advances on each rising edge from the inputs the bench drove
   always @(posedge clk) begin
      bit readyNow;
      bit popNow;
      if (rst) begin
         modelFifo.delete();
         modelStage.delete();
         modelDrop = 0;
      end else begin
         readyNow = modelReady();
         popNow   = (modelFifo.size() > 0) && bus.out_ready;
         if (popNow) void'(modelFifo.pop_front());
         if (modelStage.size() > 0) modelFifo.push_back(modelStage.pop_front());
         if (bus.in_valid) begin
            if (readyNow)
               modelStage.push_back(correctEntry(bus.in_quotient, bus.in_remainder,
                                                 bus.in_divisor, bus.in_dividend));
            else
               modelDrop = 1;
         end
      end
   end

   // Compare process: every falling edge, DUT outputs against the model
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("in_ready", 32'(bus.in_ready), 32'(modelReady()));
         checkOutput("fill", 32'(bus.fill), 32'(modelFifo.size()));
         checkOutput("drop_err", 32'(bus.drop_err), 32'(modelDrop));
         checkOutput("out_valid", 32'(bus.out_valid), 32'(modelFifo.size() > 0));
         if (modelFifo.size() > 0) begin
            checkOutput("out_quotient", 32'(bus.out_quotient), 32'(modelFifo[0].q));
            checkOutput("out_remainder", 32'(bus.out_remainder), 32'(modelFifo[0].r));
            checkOutput("out_dbz", 32'(bus.out_div_by_zero), 32'(modelFifo[0].dbz));
         end else begin
            checkOutput("idle_quotient", 32'(bus.out_quotient), 32'd0);
            checkOutput("idle_remainder", 32'(bus.out_remainder), 32'd0);
            checkOutput("idle_dbz", 32'(bus.out_div_by_zero), 32'd0);
         end
      end
   end

   task automatic applyStimulus(bit v, logic [15:0] q, logic [16:0] rem,
                                logic [15:0] dv, logic [15:0] dd, bit ordy);
      bus.in_valid     = v;
      bus.in_quotient  = q;
      bus.in_remainder = rem;
      bus.in_divisor   = dv;
      bus.in_dividend  = dd;
      bus.out_ready    = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 0);
      step();
      checkEn = 1;
      step();
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_fill", 32'(bus.fill), 32'd0);
      checkOutput("rst_drop_err", 32'(bus.drop_err), 32'd0);
      rst = 1'b0;
      step();
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Basic result with two-cycle latency then pop
      applyStimulus(1, 16'd14, 17'h00002, 16'd7, 16'd100, 1);
      step();
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 1);
      checkOutput("basic_not_yet", 32'(bus.out_valid), 32'd0);
      step();
      checkOutput("basic_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("basic_q", 32'(bus.out_quotient), 32'd14);
      checkOutput("basic_r", 32'(bus.out_remainder), 32'd2);
      checkOutput("basic_dbz", 32'(bus.out_div_by_zero), 32'd0);
      checkOutput("basic_fill", 32'(bus.fill), 32'd1);
      checkOutput("model_basic_q", 32'(modelFifo.size() > 0 ? modelFifo[0].q : 16'd0), 32'd14);
      step();
      checkOutput("basic_popped", 32'(bus.fill), 32'd0);

      // Negative remainder gets the divisor added back
      applyStimulus(1, 16'h000E, 17'h1FFFB, 16'd7, 16'd50, 1);
      step();
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 1);
      step();
      checkOutput("corr_r", 32'(bus.out_remainder), 32'd2);
      checkOutput("corr_q", 32'(bus.out_quotient), 32'd14);
      checkOutput("model_corr_r", 32'(modelFifo.size() > 0 ? modelFifo[0].r : 16'd0), 32'd2);
      step();

      // Divide by zero
      applyStimulus(1, 16'h5555, 17'h0ABCD, 16'd0, 16'h1234, 1);
      step();
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 1);
      step();
      checkOutput("dbz_q", 32'(bus.out_quotient), 32'hFFFF);
      checkOutput("dbz_r", 32'(bus.out_remainder), 32'h1234);
      checkOutput("dbz_flag", 32'(bus.out_div_by_zero), 32'd1);
      step();

      // Backpressure until full, then a dropped third result
      applyStimulus(1, 16'h00A1, 17'h00003, 16'd9, 16'h003A, 0);
      step();
      applyStimulus(1, 16'h00B2, 17'h1FFFF, 16'd4, 16'h000B, 0);
      step();
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 0);
      step();
      checkOutput("full_fill", 32'(bus.fill), 32'd2);
      checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
      applyStimulus(1, 16'h00C3, 17'h00001, 16'd5, 16'h0010, 0);
      step();
      checkOutput("drop_set", 32'(bus.drop_err), 32'd1);
      checkOutput("drop_fill", 32'(bus.fill), 32'd2);
      checkOutput("drop_head", 32'(bus.out_quotient), 32'h00A1);
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 1);
      step();
      checkOutput("pop_a_head", 32'(bus.out_quotient), 32'h00B2);
      checkOutput("pop_a_rem", 32'(bus.out_remainder), 32'd3);
      step();
      checkOutput("pop_b_fill", 32'(bus.fill), 32'd0);
      checkOutput("pop_b_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("drop_sticky", 32'(bus.drop_err), 32'd1);

      // Back-to-back traffic with a draining consumer exercises push+pop and wrap
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, 16'(i * 3 + 1), 17'($urandom_range(0, 131071)),
                       16'($urandom_range(1, 65535)), 16'($urandom_range(0, 65535)), 1);
         step();
      end
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 1);
      step();
      step();

      // Reset with one FIFO entry plus one in the correction register
      applyStimulus(1, 16'h0111, 17'h00004, 16'd6, 16'd1, 0);
      step();
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 0);
      step();
      applyStimulus(1, 16'h0222, 17'h00005, 16'd6, 16'd2, 0);
      step();
      rst = 1'b1;
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 0);
      step();
      rst = 1'b0;
      checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mid_rst_fill", 32'(bus.fill), 32'd0);
      checkOutput("mid_rst_drop", 32'(bus.drop_err), 32'd0);
      step();
      checkOutput("mid_rst_discard", 32'(bus.fill), 32'd0);
      applyStimulus(1, 16'h0333, 17'h00001, 16'd3, 16'd4, 1);
      step();
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 1);
      checkOutput("post_rst_lat", 32'(bus.out_valid), 32'd0);
      step();
      checkOutput("post_rst_q", 32'(bus.out_quotient), 32'h0333);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         applyStimulus($urandom_range(0, 9) < 6,
                       16'($urandom_range(0, 65535)),
                       17'($urandom_range(0, 131071)),
                       ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)),
                       16'($urandom_range(0, 65535)),
                       $urandom_range(0, 9) < 6);
         step();
      end
      rst = 1'b0;
      applyStimulus(0, 16'd0, 17'd0, 16'd0, 16'd0, 1);
      step();
      step();
      step();
      checkEn = 0;

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
